// File: rtl/axis_fifo_lutn_pkg.sv
// Shared helpers for axis_fifo_lutn: sizing functions and the parameter legality test.
package axis_fifo_lutn_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Slot width: payload plus one bit when tlast is carried.
  function automatic int slot_w(input int width, input int use_last);
    return width + ((use_last != 0) ? 1 : 0);
  endfunction

  function automatic bit params_ok(input int depth_log2, input int afull_lvl);
    return (depth_log2 >= 1) && (depth_log2 <= 5) &&
           (afull_lvl >= 0) && (afull_lvl < (1 << depth_log2));
  endfunction

endpackage

// File: rtl/axis_fifo_lutn_mem.sv
// DEPTH x SLOT_W distributed-RAM array: synchronous write, asynchronous read, no reset.
module axis_fifo_lutn_mem #(
  parameter int DEPTH_LOG2 = 1,
  parameter int SLOT_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [SLOT_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [SLOT_W-1:0]     rdata_o
);

  logic [SLOT_W-1:0] mem_q [(1 << DEPTH_LOG2)];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo_lutn.sv
// Register/LUT-based AXI-Stream FIFO with programmable depth, optional tlast and almost-full.
// Both handshake flags are registered from next-cycle occupancy, so no s_rx -> m_tx comb path exists.
module axis_fifo_lutn
  import axis_fifo_lutn_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 1,
  parameter int USE_LAST   = 0,
  parameter int AFULL_LVL  = 1,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      s_rx_tdata,
  input  logic                  s_rx_tlast,
  input  logic                  s_rx_tvalid,
  output logic                  s_rx_tready,
  output logic [WIDTH-1:0]      m_tx_tdata,
  output logic                  m_tx_tlast,
  output logic                  m_tx_tvalid,
  input  logic                  m_tx_tready,
  output logic [DEPTH_LOG2:0]   used,
  output logic                  afull
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int PTR_W  = clog2(DEPTH) + 1;
  localparam int SLOT_W = slot_w(WIDTH, USE_LAST);
  localparam logic [PTR_W-1:0] DEPTH_C    = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_TH_C = PTR_W'(DEPTH - AFULL_LVL);

  if (!params_ok(DEPTH_LOG2, AFULL_LVL)) begin : g_param_err
    $error("axis_fifo_lutn: DEPTH_LOG2 must be 1..5 and AFULL_LVL < DEPTH");
  end

  if (BYPASS != 0) begin : g_bypass
    logic unused_bypass_s;
    assign unused_bypass_s = clk ^ rst_n;
    assign m_tx_tdata  = s_rx_tdata;
    assign m_tx_tlast  = (USE_LAST != 0) ? s_rx_tlast : 1'b0;
    assign m_tx_tvalid = s_rx_tvalid;
    assign s_rx_tready = m_tx_tready;
    assign used        = '0;
    assign afull       = 1'b0;
  end else begin : g_fifo
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W-1:0]  used_s, used_nx_s;
    logic              rdy_q, rdy_d, vld_q, vld_d, afull_q, afull_d;
    logic              push_s, pop_s;
    logic [SLOT_W-1:0] wslot_s, rslot_s;

    always_comb begin
      push_s    = s_rx_tvalid & rdy_q;
      pop_s     = vld_q & m_tx_tready;
      used_s    = wptr_q - rptr_q;
      wptr_d    = wptr_q + {{(PTR_W-1){1'b0}}, push_s};
      rptr_d    = rptr_q + {{(PTR_W-1){1'b0}}, pop_s};
      used_nx_s = used_s + {{(PTR_W-1){1'b0}}, push_s} - {{(PTR_W-1){1'b0}}, pop_s};
      rdy_d     = (used_nx_s < DEPTH_C);
      vld_d     = (used_nx_s != {PTR_W{1'b0}});
      afull_d   = (used_nx_s >= AFULL_TH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        rdy_q   <= 1'b1;
        vld_q   <= 1'b0;
        afull_q <= 1'b0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        rdy_q   <= rdy_d;
        vld_q   <= vld_d;
        afull_q <= afull_d;
      end
    end

    axis_fifo_lutn_mem #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .SLOT_W     (SLOT_W)
    ) u_mem (
      .clk_i   (clk),
      .we_i    (push_s),
      .waddr_i (wptr_q[DEPTH_LOG2-1:0]),
      .wdata_i (wslot_s),
      .raddr_i (rptr_q[DEPTH_LOG2-1:0]),
      .rdata_o (rslot_s)
    );

    if (USE_LAST != 0) begin : g_last
      assign wslot_s    = {s_rx_tlast, s_rx_tdata};
      assign m_tx_tlast = rslot_s[SLOT_W-1];
    end else begin : g_nolast
      logic unused_tlast_s;
      assign unused_tlast_s = s_rx_tlast;
      assign wslot_s        = s_rx_tdata;
      assign m_tx_tlast     = 1'b0;
    end

    assign m_tx_tdata  = rslot_s[WIDTH-1:0];
    assign s_rx_tready = rdy_q;
    assign m_tx_tvalid = vld_q;
    assign afull       = afull_q;
    assign used        = used_s;
  end

endmodule

// File: doc/axis_fifo_lutn.md
Name: axis_fifo_lutn

Overview:
Parametrised LUT/register-based AXI-Stream FIFO with a programmable depth. It decouples tready backpressure between pipeline stages. It is the generalised successor of the fixed 2-slot tready-relaxing FIFO, and adds configurable depth, optional tlast carriage, an occupancy output and an almost-full flag for upstream throttling. It sits inline on any AXIS datapath (DMA, DSP chains) where a shallow, register-timed buffer is needed without block RAM.

Parameters:
WIDTH, 32, tdata width in bits (>=1)
DEPTH_LOG2, 1, log2 of slot count; DEPTH = 2**DEPTH_LOG2, legal 1..5 (2..32 slots)
USE_LAST, 0, 1 = store and forward tlast alongside tdata; 0 = m_tx_tlast tied 0
AFULL_LVL, 1, almost-full asserts when used >= DEPTH - AFULL_LVL; legal 0..DEPTH-1
BYPASS, 0, 1 = pure wire-through; m_tx_* = s_rx_*, s_rx_tready = m_tx_tready, used = 0, afull = 0

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active low
s_rx_tdata  in  WIDTH  input payload
s_rx_tlast  in  1  input packet end (ignored if USE_LAST=0)
s_rx_tvalid  in  1  input valid
s_rx_tready  out  1  input ready, registered
m_tx_tdata  out  WIDTH  output payload, muxed from storage at rptr
m_tx_tlast  out  1  output packet end
m_tx_tvalid  out  1  output valid, registered
m_tx_tready  in  1  output ready
used  out  DEPTH_LOG2+1  current occupancy 0..DEPTH
afull  out  1  almost-full flag, registered

Behaviour:
- Reset (rst_n low, asynchronous): rptr = wptr = 0; s_rx_tready = 1; m_tx_tvalid = 0; afull = (AFULL_LVL == DEPTH-1 ? 0 : 0) = 0; used = 0. Storage is not reset. Reset mid-transfer drops all contents. First push is allowed in the cycle after deassertion.
- Pointers are DEPTH_LOG2+1 bits wide and wrap naturally. used = wptr - rptr, mod 2**(DEPTH_LOG2+1). Storage index is ptr[DEPTH_LOG2-1:0].
- push = s_rx_tvalid & s_rx_tready. pop = m_tx_tvalid & m_tx_tready.
- On push: write {tlast, tdata} to slot wptr, then wptr++.
- On pop: rptr++.
- Next occupancy: used_nx = used + push - pop.
- Registered flags, computed from used_nx:
  - s_rx_tready <= (used_nx < DEPTH)
  - m_tx_tvalid <= (used_nx != 0)
  - afull <= (used_nx >= DEPTH - AFULL_LVL)
- Latency: a word pushed into an empty FIFO appears on m_tx (tvalid=1) in the next cycle. There is no combinational path from s_rx to m_tx or from m_tx_tready to s_rx_tready.
- Simultaneous push and pop at any level: used is unchanged and both flags hold.
- Full (used = DEPTH): tready = 0, so no write occurs. A pop at full raises tready in the following cycle; there is no same-cycle refill.
- Empty: tvalid = 0 and m_tx_tdata is don't-care. A push at empty makes tvalid 1 next cycle.
- m_tx_tdata and m_tx_tlast remain stable while tvalid=1 and tready=0 (AXIS rule).
- Sustained throughput is 1 word/clk for DEPTH >= 2 when both sides are continuously ready.
- Invariants: used <= DEPTH; s_rx_tready == (used < DEPTH); m_tx_tvalid == (used != 0).

Decomposition:
- Shared package/header holds:
  - helper function clog2
  - DEPTH_LOG2 legality check: elaboration error if outside 1..5 or AFULL_LVL >= DEPTH
  - localparam SLOT_W = WIDTH + USE_LAST
- One natural sub-module, axis_fifo_lutn_mem: DEPTH x SLOT_W distributed-RAM array with synchronous write and asynchronous read. The control logic (pointers, flags) stays in the top.
- BYPASS is selected by a generate branch in the top.

Test Plan:
1. Reset then idle: rst_n=0 for 3 clk, release -> s_rx_tready=1, m_tx_tvalid=0, used=0, afull=0.
2. DEPTH_LOG2=2, m_tx_tready=0, push 0x11,0x22,0x33,0x44 on consecutive clks -> used 1,2,3,4. s_rx_tready drops the cycle after the 4th push. afull (AFULL_LVL=1) rises after the 3rd push. A 5th word is held off.
3. From full, m_tx_tready=1 for one cycle -> 0x11 popped, used=3, s_rx_tready=1 next cycle. Then drain all -> order 0x22,0x33,0x44, tvalid falls after the last pop.
4. Continuous streaming, both sides always ready, 100 incrementing words -> one word/clk after 1-cycle latency, no loss or reorder, used stays at 1.
5. Random tvalid/tready (50%) for 10k cycles with USE_LAST=1, tlast every 7th word -> scoreboard matches data and tlast, invariants hold every cycle, m_tx_tdata stable under stall.
6. rst_n asserted asynchronously mid-clock with used=3 -> outputs go to reset values immediately, without waiting for an edge. After release, the old data never appears and a new push of 0xAA is the first word out.
